// File: rtl/matriz_varredura_pkg.sv
// Shared constants, types and pixel helper for the 5x7 LED matrix scanner.
package matriz_varredura_pkg;

   localparam int unsigned N_COLUNAS = 5;
   localparam int unsigned N_LINHAS  = 7;
   localparam int unsigned N_PIXELS  = N_COLUNAS * N_LINHAS;
   localparam int unsigned CW_COL    = 3;
   localparam int unsigned IW_PIXEL  = $clog2(N_PIXELS);

   typedef logic [N_PIXELS-1:0]  quadro_t;
   typedef logic [N_LINHAS-1:0]  linha_t;
   typedef logic [N_COLUNAS-1:0] coluna_t;
   typedef logic [CW_COL-1:0]    indice_col_t;

   localparam linha_t      LINHA_APAGADA  = 7'h7F;
   localparam coluna_t     COLUNA_NENHUMA = 5'b00000;
   localparam quadro_t     QUADRO_APAGADO = '1;
   localparam indice_col_t ULTIMA_COLUNA  = 3'd4;

   // Row data (active-low) of one column of a row-major frame.
   function automatic linha_t extrai_coluna(input quadro_t q, input indice_col_t c);
      linha_t l;
      l = LINHA_APAGADA;
      for (int r = 0; r < int'(N_LINHAS); r++) begin
         l[r] = q[IW_PIXEL'(r * int'(N_COLUNAS) + int'(c))];
      end
      return l;
   endfunction

endpackage

// File: rtl/matriz_varredura_contador.sv
// Dwell prescaler plus column counter; flags the last cycle of column 4.
module contador_varredura
   import matriz_varredura_pkg::*;
#(
   parameter  int unsigned DIV_VARREDURA = 50000,
   localparam int unsigned CW            = $clog2(DIV_VARREDURA)
) (
   input  logic              clk,
   input  logic              reset,
   output logic [CW-1:0]     cnt,
   output indice_col_t       col,
   output logic              fronteira_c
);

   logic fim_dwell_c;

   assign fim_dwell_c = (cnt == CW'(DIV_VARREDURA - 1));
   assign fronteira_c = fim_dwell_c && (col == ULTIMA_COLUNA);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         col <= '0;
      end else if (fim_dwell_c) begin
         cnt <= '0;
         col <= (col == ULTIMA_COLUNA) ? '0 : col + indice_col_t'(1);
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/matriz_varredura.sv
// 5x7 LED matrix column scanner with double-buffered frame, committed only at frame wrap.
module matriz_varredura
   import matriz_varredura_pkg::*;
#(
   parameter int unsigned DIV_VARREDURA = 50000,
   parameter int unsigned TEMPO_APAGADO = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_PIXELS-1:0]  quadro,
   input  logic                 carregar,
   output logic [N_COLUNAS-1:0] colunas,
   output logic [N_LINHAS-1:0]  linhas,
   output logic                 pendente,
   output logic                 fim_quadro
);

   localparam int unsigned CW = $clog2(DIV_VARREDURA);

   logic [CW-1:0] cnt;
   indice_col_t   col;
   logic          fronteira_c;
   logic          apagado_c;
   quadro_t       sombra;
   quadro_t       ativo;

   contador_varredura #(
      .DIV_VARREDURA (DIV_VARREDURA)
   ) u_contador (
      .clk         (clk),
      .reset       (reset),
      .cnt         (cnt),
      .col         (col),
      .fronteira_c (fronteira_c)
   );

   // Shadow capture and boundary commit; a load on the boundary keeps the new frame pending.
   always_ff @(posedge clk) begin
      if (reset) begin
         sombra     <= QUADRO_APAGADO;
         ativo      <= QUADRO_APAGADO;
         pendente   <= 1'b0;
         fim_quadro <= 1'b0;
      end else begin
         fim_quadro <= fronteira_c;
         if (fronteira_c && pendente) begin
            ativo <= sombra;
         end
         if (carregar) begin
            sombra   <= quadro;
            pendente <= 1'b1;
         end else if (fronteira_c) begin
            pendente <= 1'b0;
         end
      end
   end

   assign apagado_c = (32'(cnt) + 32'd1 <= TEMPO_APAGADO);

   // Pins decoded from registered state only.
   always_comb begin
      colunas = COLUNA_NENHUMA;
      linhas  = LINHA_APAGADA;
      if (!apagado_c) begin
         colunas = coluna_t'(1) << col;
         linhas  = extrai_coluna(ativo, col);
      end
   end

endmodule

// File: tb/tb_matriz_varredura.sv
// Randomized plus directed bench for matriz_varredura against a cycle-count based display model.
module tb_matriz_varredura;

   localparam int DIV = 4;
   localparam int PER = 5 * DIV;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [34:0] quadro = '1;
   logic        carregar = 1'b0;
   logic [4:0]  colunas, colunas0;
   logic [6:0]  linhas, linhas0;
   logic        pendente, pendente0, fim_quadro, fim_quadro0;

   int n_vec = 0;
   int n_err = 0;

   // Model: time since reset plus displayed and waiting frames.
   int          t = 0;
   bit          primed = 1'b0;
   logic [34:0] m_ativo = '1;
   logic [34:0] m_sombra = '1;
   bit          m_pend = 1'b0;
   bit          m_fim = 1'b0;

   matriz_varredura #(.DIV_VARREDURA(DIV), .TEMPO_APAGADO(1)) dut (
      .clk(clk), .reset(reset), .quadro(quadro), .carregar(carregar),
      .colunas(colunas), .linhas(linhas), .pendente(pendente), .fim_quadro(fim_quadro)
   );

   matriz_varredura #(.DIV_VARREDURA(DIV), .TEMPO_APAGADO(0)) dut0 (
      .clk(clk), .reset(reset), .quadro(quadro), .carregar(carregar),
      .colunas(colunas0), .linhas(linhas0), .pendente(pendente0), .fim_quadro(fim_quadro0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t (t=%0d): got %0h expected %0h", tag, $time, t, got, exp);
      end
   endtask

   function automatic logic [6:0] coluna_de(input logic [34:0] q, input int c);
      logic [6:0] l;
      for (int r = 0; r < 7; r++) l[r] = q[6'(r * 5 + c)];
      return l;
   endfunction

   task automatic check_model();
      int k, c;
      k = t % DIV;
      c = (t / DIV) % 5;
      chk("colunas", 64'(colunas), (k < 1) ? 64'd0 : 64'(1 << c));
      chk("linhas", 64'(linhas), (k < 1) ? 64'h7F : 64'(coluna_de(m_ativo, c)));
      chk("colunas_t0", 64'(colunas0), 64'(1 << c));
      chk("linhas_t0", 64'(linhas0), 64'(coluna_de(m_ativo, c)));
      chk("pendente", 64'(pendente), 64'(m_pend));
      chk("fim_quadro", 64'(fim_quadro), 64'(m_fim));
      chk("fim_quadro_t0", 64'(fim_quadro0), 64'(m_fim));
   endtask

   // One clock: check current outputs, drive inputs, advance model across the edge.
   task automatic tick(input bit rst, input bit ld, input logic [34:0] q);
      bit bnd;
      @(negedge clk);
      if (primed) check_model();
      reset    = rst;
      carregar = ld;
      quadro   = q;
      if (rst) begin
         t = 0; m_ativo = '1; m_sombra = '1; m_pend = 0; m_fim = 0;
         primed = 1'b1;
      end else begin
         bnd   = (t % PER == PER - 1);
         m_fim = bnd;
         if (bnd && m_pend) m_ativo = m_sombra;
         if (ld) begin
            m_sombra = q;
            m_pend   = 1'b1;
         end else if (bnd) begin
            m_pend = 1'b0;
         end
         t++;
      end
   endtask

   task automatic idle_until(input int target);
      for (int i = 0; i < 1000 && t != target; i++) tick(0, 0, '1);
      if (t != target) chk("idle_timeout", 64'(t), 64'(target));
   endtask

   // Directed look right after the next edge, against spec-derived constants.
   task automatic sample_dir(input string tag, input logic [4:0] ec, input logic [6:0] el);
      @(posedge clk);
      #1;
      chk({tag, "_col"}, 64'(colunas), 64'(ec));
      chk({tag, "_lin"}, 64'(linhas), 64'(el));
   endtask

   logic [34:0] seta, fa, fb, fc;
   logic [6:0]  seta_col [5];

   initial begin
      seta = {5'b11011, 5'b10001, 5'b00000, 5'b11011, 5'b11011, 5'b11011, 5'b11011};
      seta_col[0] = 7'b1101111; seta_col[1] = 7'b1001111; seta_col[2] = 7'b0000000;
      seta_col[3] = 7'b1001111; seta_col[4] = 7'b1101111;

      // Blank scan for 3 frames.
      tick(1, 0, '1);
      tick(1, 0, '1);
      for (int i = 0; i < 3 * PER; i++) tick(0, 0, '1);

      // Down arrow loaded at cycle 2.
      tick(1, 0, '1);
      idle_until(2);
      tick(0, 1, seta);
      for (int c = 0; c < 5; c++) begin
         idle_until(PER + c * DIV + 1);
         sample_dir("seta", 5'(1 << c), seta_col[c]);
      end

      // A then B in column 2: only B appears.
      fa = 35'({$urandom(), $urandom()});
      fb = 35'({$urandom(), $urandom()});
      idle_until(2 * PER + 2 * DIV + 1);
      tick(0, 1, fa);
      tick(0, 1, fb);
      idle_until(3 * PER + 1);
      sample_dir("b_wins", 5'b00001, coluna_de(fb, 0));

      // Load C on the boundary while A pending.
      fc = 35'({$urandom(), $urandom()});
      idle_until(3 * PER + 5);
      tick(0, 1, fa);
      idle_until(4 * PER - 1);
      tick(0, 1, fc);
      sample_dir("a_commit", 5'b00000, 7'h7F);
      idle_until(4 * PER + 2 * DIV + 2);
      sample_dir("a_shown", 5'b00100, coluna_de(fa, 2));
      idle_until(5 * PER + 2 * DIV + 2);
      sample_dir("c_shown", 5'b00100, coluna_de(fc, 2));

      // Reset during column 3 with a frame pending.
      tick(0, 1, fa);
      idle_until(6 * PER + 3 * DIV + 2);
      tick(1, 0, '1);
      @(posedge clk);
      #1;
      chk("rst_col", 64'(colunas), 64'd0);
      chk("rst_lin", 64'(linhas), 64'h7F);
      chk("rst_pend", 64'(pendente), 64'd0);
      chk("rst_fim", 64'(fim_quadro), 64'd0);
      tick(0, 0, '1);

      // Random loads, held strobes and occasional resets.
      for (int i = 0; i < 1500; i++) begin
         int sel;
         sel = int'($urandom_range(0, 199));
         if (sel == 0) tick(1, 0, '1);
         else if (sel < 25) tick(0, 1, 35'({$urandom(), $urandom()}));
         else if (sel < 28) begin
            for (int j = 0; j < 3; j++) tick(0, 1, 35'({$urandom(), $urandom()}));
         end else tick(0, 0, 35'({$urandom(), $urandom()}));
      end
      tick(0, 0, '1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
